// File: rtl/counter_decoder.sv
// counter_decoder: decode the pssw105 4-bit counter stream and track sequence lock, errors and ctrl toggles.
//   clk, rst_n (async, active-low) | in_valid, in_code[3:0] sample input
//   out_valid, ctrl_out, cnt_out[2:0] decoded sample | locked, seq_err, err_cnt, toggle_cnt status
//   Optional: define COUNTER_DEC_TOGGLE_CNT_EN to count ctrl flips while locked (else toggle_cnt = 0).
module counter_decoder #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_code,
  output logic             out_valid,
  output logic             ctrl_out,
  output logic [2:0]       cnt_out,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] toggle_cnt
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state_q, state_d;
  logic [2:0] ref_cnt_q, ref_cnt_d, cnt_out_q, cnt_out_d, cnt;
  logic [3:0] good_run_q, good_run_d, bad_run_q, bad_run_d;
  logic first_q, first_d, out_valid_q, out_valid_d, ctrl_out_q, ctrl_out_d;
  logic locked_q, locked_d, seq_err_q, seq_err_d, ctrl, match;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`ifdef COUNTER_DEC_TOGGLE_CNT_EN
  logic prev_ctrl_q, prev_ctrl_d;
  logic [ERR_W-1:0] toggle_cnt_q, toggle_cnt_d;
  always_comb begin
    prev_ctrl_d  = in_valid ? ctrl : prev_ctrl_q;
    toggle_cnt_d = (in_valid && state_q == LOCKED && ctrl != prev_ctrl_q && toggle_cnt_q != '1)
                   ? toggle_cnt_q + ERR_W'(1) : toggle_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_ctrl_q  <= 1'b0;
      toggle_cnt_q <= '0;
    end else begin
      prev_ctrl_q  <= prev_ctrl_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  assign toggle_cnt = toggle_cnt_q;
`else
  assign toggle_cnt = '0;
`endif
  always_comb begin
    ctrl        = in_code[3];
    cnt         = ctrl ? ~in_code[2:0] : in_code[2:0];
    match       = cnt == 3'(ref_cnt_q + 3'd1);
    state_d     = state_q;
    ref_cnt_d   = ref_cnt_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    first_d     = first_q;
    out_valid_d = 1'b0;
    ctrl_out_d  = ctrl_out_q;
    cnt_out_d   = cnt_out_q;
    seq_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (in_valid) begin
      out_valid_d = 1'b1;
      ctrl_out_d  = ctrl;
      cnt_out_d   = cnt;
      if (state_q == HUNT) begin
        // In HUNT the reference simply follows the stream; a break restarts the run.
        ref_cnt_d  = cnt;
        first_d    = 1'b0;
        good_run_d = (first_q || !match) ? 4'd1 : good_run_q + 4'd1;
        if (good_run_d == 4'(LOCK_CNT)) begin
          state_d   = LOCKED;
          bad_run_d = 4'd0;
        end
      end else begin
        // Flywheel: the reference advances regardless of what was received.
        ref_cnt_d = ref_cnt_q + 3'd1;
        bad_run_d = match ? 4'd0 : bad_run_q + 4'd1;
        seq_err_d = !match;
        err_cnt_d = (!match && err_cnt_q != '1) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
        if (bad_run_d == 4'(LOSS_CNT)) begin
          state_d = HUNT;
          first_d = 1'b1;
        end
      end
    end
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= HUNT;
      ref_cnt_q   <= 3'd0;
      good_run_q  <= 4'd0;
      bad_run_q   <= 4'd0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      ctrl_out_q  <= 1'b0;
      cnt_out_q   <= 3'd0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      ctrl_out_q  <= ctrl_out_d;
      cnt_out_q   <= cnt_out_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  assign out_valid = out_valid_q;
  assign ctrl_out  = ctrl_out_q;
  assign cnt_out   = cnt_out_q;
  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_counter_decoder.sv
// tb_counter_decoder: table-driven scoreboard bench for counter_decoder (ERR_W=8 and ERR_W=2 instances).
module tb_counter_decoder;
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [3:0] in_code = 0;
  logic out_valid, ctrl_out, locked, seq_err;
  logic [2:0] cnt_out;
  logic [7:0] err_cnt, toggle_cnt;
  logic ov2, ctrl2, lk2, se2;
  logic [2:0] cnt2;
  logic [1:0] err2, tog2;
  int errors = 0, checks = 0;

  typedef struct {
    logic v; logic [3:0] code;
    logic ov, ctrl; logic [2:0] cnt; logic lk, se;
    logic [7:0] err; logic [1:0] err2; logic [7:0] tog;
  } vec_t;
  vec_t tbl[22];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  counter_decoder #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .out_valid(out_valid), .ctrl_out(ctrl_out), .cnt_out(cnt_out), .locked(locked),
    .seq_err(seq_err), .err_cnt(err_cnt), .toggle_cnt(toggle_cnt));

  counter_decoder #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .out_valid(ov2), .ctrl_out(ctrl2), .cnt_out(cnt2), .locked(lk2),
    .seq_err(se2), .err_cnt(err2), .toggle_cnt(tog2));

  function automatic vec_t mk(logic v, logic [3:0] code, logic ov, logic ctrl, logic [2:0] cnt,
                              logic lk, logic se, logic [7:0] err, logic [1:0] e2, logic [7:0] tog);
    vec_t t;
    t.v = v; t.code = code; t.ov = ov; t.ctrl = ctrl; t.cnt = cnt;
    t.lk = lk; t.se = se; t.err = err; t.err2 = e2; t.tog = tog;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int idx);
    vec_t e;
    @(negedge clk);
    in_valid = t.v;
    in_code  = t.code;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
      return;
    end
    e = exp_q.pop_front();
    chk("out_valid", idx, {7'd0, out_valid}, {7'd0, e.ov});
    chk("ctrl_out", idx, {7'd0, ctrl_out}, {7'd0, e.ctrl});
    chk("cnt_out", idx, {5'd0, cnt_out}, {5'd0, e.cnt});
    chk("locked", idx, {7'd0, locked}, {7'd0, e.lk});
    chk("seq_err", idx, {7'd0, seq_err}, {7'd0, e.se});
    chk("err_cnt", idx, err_cnt, e.err);
    chk("err_cnt_w2", idx, {6'd0, err2}, {6'd0, e.err2});
    chk("locked_w2", idx, {7'd0, lk2}, {7'd0, e.lk});
`ifdef COUNTER_DEC_TOGGLE_CNT_EN
    chk("toggle_cnt", idx, toggle_cnt, e.tog);
`else
    chk("toggle_cnt", idx, toggle_cnt, 8'd0);
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 0, {7'd0, out_valid}, 8'd0);
    chk({tag, "_ctrl_out"}, 0, {7'd0, ctrl_out}, 8'd0);
    chk({tag, "_cnt_out"}, 0, {5'd0, cnt_out}, 8'd0);
    chk({tag, "_locked"}, 0, {7'd0, locked}, 8'd0);
    chk({tag, "_seq_err"}, 0, {7'd0, seq_err}, 8'd0);
    chk({tag, "_err_cnt"}, 0, err_cnt, 8'd0);
    chk({tag, "_err_cnt_w2"}, 0, {6'd0, err2}, 8'd0);
    chk({tag, "_toggle_cnt"}, 0, toggle_cnt, 8'd0);
  endtask

  initial begin
    //           v  code ov ct cnt lk se err e2 tog
    tbl[0]  = mk(1, 0,   1, 0, 0,  0, 0, 0,  0, 0);
    tbl[1]  = mk(1, 1,   1, 0, 1,  0, 0, 0,  0, 0);
    tbl[2]  = mk(1, 2,   1, 0, 2,  1, 0, 0,  0, 0);
    tbl[3]  = mk(0, 9,   0, 0, 2,  1, 0, 0,  0, 0);
    tbl[4]  = mk(1, 3,   1, 0, 3,  1, 0, 0,  0, 0);
    tbl[5]  = mk(1, 4,   1, 0, 4,  1, 0, 0,  0, 0);
    tbl[6]  = mk(1, 5,   1, 0, 5,  1, 0, 0,  0, 0);
    tbl[7]  = mk(1, 0,   1, 0, 0,  1, 1, 1,  1, 0);
    tbl[8]  = mk(1, 7,   1, 0, 7,  1, 0, 1,  1, 0);
    tbl[9]  = mk(1, 15,  1, 1, 0,  1, 0, 1,  1, 1);
    tbl[10] = mk(1, 14,  1, 1, 1,  1, 0, 1,  1, 1);
    tbl[11] = mk(1, 2,   1, 0, 2,  1, 0, 1,  1, 2);
    tbl[12] = mk(1, 0,   1, 0, 0,  1, 1, 2,  2, 2);
    tbl[13] = mk(1, 0,   1, 0, 0,  0, 1, 3,  3, 2);
    tbl[14] = mk(1, 5,   1, 0, 5,  0, 0, 3,  3, 2);
    tbl[15] = mk(1, 6,   1, 0, 6,  0, 0, 3,  3, 2);
    tbl[16] = mk(1, 7,   1, 0, 7,  1, 0, 3,  3, 2);
    tbl[17] = mk(1, 9,   1, 1, 6,  1, 1, 4,  3, 3);
    tbl[18] = mk(1, 14,  1, 1, 1,  1, 0, 4,  3, 3);
    tbl[19] = mk(1, 5,   1, 0, 5,  1, 1, 5,  3, 4);
    tbl[20] = mk(1, 3,   1, 0, 3,  1, 0, 5,  3, 4);
    tbl[21] = mk(0, 0,   0, 0, 3,  1, 0, 5,  3, 4);
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 22; i++) step(tbl[i], i);
    // Asynchronous reset between edges must clear everything at once.
    #2;
    rst_n = 0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1;
    step(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0), 100);
    step(mk(1, 2, 1, 0, 2, 0, 0, 0, 0, 0), 101);
    step(mk(1, 3, 1, 0, 3, 1, 0, 0, 0, 0), 102);
    step(mk(0, 3, 0, 0, 3, 1, 0, 0, 0, 0), 103);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
